vga_fifo_reader: RTL

Display-side consumer of the SDRAM read-back FIFO: generates 640x480@60 VGA timing and pops one 16-bit RGB565 pixel from the FIFO per active pixel.
Sits directly downstream of the SDRAM interface, on the VGA pixel clock, and drives the FIFO read strobe and the VGA pins.
Owns start-up gating (no reads until the FIFO holds data at a frame boundary) and underflow detection/recovery.

---
 rtl/vga_fifo_reader_if.sv | 18 +
 rtl/vga_fifo_reader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_fifo_reader_if.sv
// rtl/vga_fifo_reader_if.sv - read side of the SDRAM read-back FIFO as seen by the VGA reader
interface vga_fifo_reader_if;
    logic        empty_fifo;
    logic [15:0] dout;
    logic        rd_en;

    modport master (
        input  empty_fifo,
        input  dout,
        output rd_en
    );

    modport slave (
        output empty_fifo,
        output dout,
        input  rd_en
    );
endinterface

// File: rtl/vga_fifo_reader.sv
// rtl/vga_fifo_reader.sv - VGA timing generator that pops one RGB565 pixel from the FIFO per active pixel
module vga_fifo_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic              clk,
    input  logic              rst,
    vga_fifo_reader_if.master fifo,
    output logic [4:0]        vga_r,
    output logic [5:0]        vga_g,
    output logic [4:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_de,
    output logic              frame_start,
    output logic [15:0]       underflow_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_ON    = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_active;
    logic          w_frame0;
    logic          w_hs_pin;
    logic          w_vs_pin;
    logic          w_rd;
    logic          w_underflow;
    logic          r_de1;
    logic          r_hs1;
    logic          r_vs1;
    logic          r_taken1;
    logic          r_de2;
    logic          r_hs2;
    logic          r_vs2;
    logic [15:0]   r_rgb2;
    logic [15:0]   r_uf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign w_active = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
    assign w_frame0 = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_hs_pin = ((r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END)) ? SYNC_ON : !SYNC_ON;
    assign w_vs_pin = ((r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END)) ? SYNC_ON : !SYNC_ON;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The frame-boundary check shares its cycle with pixel (0,0), so that pixel is read on entry.
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_underflow = 1'b0;
        case (r_state)
            ST_WAIT, ST_RESYNC: begin
                if (w_frame0 && !fifo.empty_fifo) begin
                    w_state_nxt = ST_RUN;
                    w_rd        = w_active;
                end
            end
            ST_RUN: begin
                if (w_active) begin
                    if (fifo.empty_fifo) begin
                        w_state_nxt = ST_RESYNC;
                        w_underflow = 1'b1;
                    end else begin
                        w_rd = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end

    // Counters sit at (0,0) in WAIT during reset, so the combinational strobes are masked by rst.
    assign fifo.rd_en  = w_rd & ~rst;
    assign frame_start = w_frame0 & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uf_cnt <= '0;
        end else if (w_underflow && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de1    <= 1'b0;
            r_hs1    <= !SYNC_ON;
            r_vs1    <= !SYNC_ON;
            r_taken1 <= 1'b0;
            r_de2    <= 1'b0;
            r_hs2    <= !SYNC_ON;
            r_vs2    <= !SYNC_ON;
            r_rgb2   <= '0;
        end else begin
            r_de1    <= w_active;
            r_hs1    <= w_hs_pin;
            r_vs1    <= w_vs_pin;
            r_taken1 <= w_rd;
            r_de2    <= r_de1;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_rgb2   <= (r_de1 && r_taken1) ? fifo.dout : 16'h0000;
        end
    end

    assign vga_r         = r_rgb2[15:11];
    assign vga_g         = r_rgb2[10:5];
    assign vga_b         = r_rgb2[4:0];
    assign vga_hsync     = r_hs2;
    assign vga_vsync     = r_vs2;
    assign vga_de        = r_de2;
    assign underflow_cnt = r_uf_cnt;
endmodule
